// File: rtl/riscv_lsu.sv
// Load/store unit: one access at a time, byte-lane placement, optional split of
// misaligned accesses into two bus beats, load extension and event counters.
module riscv_lsu #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 64,
    parameter int MISALIGN_MODE = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [4:0]            rsp_rd,
    output logic [1:0]            rsp_fault,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rsp_err,
    output logic [CNT_WIDTH-1:0]  cnt_loads,
    output logic [CNT_WIDTH-1:0]  cnt_stores,
    output logic [CNT_WIDTH-1:0]  cnt_faults,
    output logic [CNT_WIDTH-1:0]  cnt_splits
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int NB2 = 2 * NB;
    localparam int OW  = $clog2(NB);

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;
    state_t state, state_next;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic                  split_q;
    logic [1:0]            fault_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [3:0]            req_size;
    logic                  legal;
    logic                  misaligned;
    logic                  req_split;
    logic [1:0]            req_fault;
    logic [4:0]            req_end;

    always_comb begin
        req_size = 4'd1 << req_funct3[1:0];
        if (req_we)
            legal = (req_funct3 <= 3'd2) || (DATA_WIDTH == 64 && req_funct3 == 3'd3);
        else
            legal = (req_funct3 <= 3'd2) || req_funct3 == 3'd4 || req_funct3 == 3'd5 ||
                    (DATA_WIDTH == 64 && (req_funct3 == 3'd3 || req_funct3 == 3'd6));
        misaligned = (req_addr[3:0] & (req_size - 4'd1)) != 4'd0;
        req_end    = 5'(req_addr[OW-1:0]) + 5'(req_size);
        req_split  = (MISALIGN_MODE == 1) && (req_end > 5'(NB));
        if (!legal)
            req_fault = 2'd2;
        else if (misaligned && MISALIGN_MODE == 0)
            req_fault = 2'd1;
        else
            req_fault = 2'd0;
    end

    logic [OW-1:0]         off_q;
    logic [3:0]            size_q;
    logic [ADDR_WIDTH-1:0] beat0_addr;
    logic [NB2-1:0]        be_full;
    logic [2*DATA_WIDTH-1:0] wd_full;

    always_comb begin
        off_q      = addr_q[OW-1:0];
        size_q     = 4'd1 << f3_q[1:0];
        beat0_addr = {addr_q[ADDR_WIDTH-1:OW], OW'(0)};
        be_full    = NB2'(8'hFF >> (4'd8 - size_q)) << off_q;
        wd_full    = {{DATA_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};
    end

    // Load assembly: concatenate both beats, drop the leading lanes, then extend.
    logic [DATA_WIDTH-1:0] lo_src, hi_src, raw, mask, ext;
    logic                  sign_bit;

    always_comb begin
        lo_src   = (state == WAIT0) ? mem_rdata : lo_q;
        hi_src   = (state == WAIT1) ? mem_rdata : '0;
        raw      = DATA_WIDTH'({hi_src, lo_src} >> {off_q, 3'b000});
        mask     = ~({DATA_WIDTH{1'b1}} << {size_q, 3'b000});
        sign_bit = |(raw & mask & ~(mask >> 1));
        ext      = (raw & mask) | ((sign_bit && !f3_q[2]) ? ~mask : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        rsp_rd        = '0;
        rsp_fault     = '0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_be        = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (req_fault != 2'd0) ? RESP : ISSUE0;
            end
            ISSUE0: begin
                mem_req_valid = 1'b1;
                mem_we        = we_q;
                mem_addr      = beat0_addr;
                mem_wdata     = wd_full[DATA_WIDTH-1:0];
                mem_be        = be_full[NB-1:0];
                if (mem_req_ready) state_next = WAIT0;
            end
            WAIT0: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err)  state_next = RESP;
                    else if (split_q) state_next = ISSUE1;
                    else              state_next = RESP;
                end
            end
            ISSUE1: begin
                mem_req_valid = 1'b1;
                mem_we        = we_q;
                mem_addr      = beat0_addr + ADDR_WIDTH'(NB);
                mem_wdata     = wd_full[2*DATA_WIDTH-1:DATA_WIDTH];
                mem_be        = be_full[NB2-1:NB];
                if (mem_req_ready) state_next = WAIT1;
            end
            WAIT1: begin
                if (mem_rsp_valid) state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_rd    = rd_q;
                rsp_fault = fault_q;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic accept, bus_err;
    assign accept  = (state == IDLE) && req_valid;
    assign bus_err = (state == WAIT0 || state == WAIT1) && mem_rsp_valid && mem_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            split_q    <= 1'b0;
            fault_q    <= '0;
            lo_q       <= '0;
            rdata_q    <= '0;
            cnt_loads  <= '0;
            cnt_stores <= '0;
            cnt_faults <= '0;
            cnt_splits <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                split_q <= req_split && (req_fault == 2'd0);
                fault_q <= req_fault;
                rdata_q <= '0;
            end
            if (state == WAIT0 && mem_rsp_valid) begin
                lo_q <= mem_rdata;
                if (mem_rsp_err)   fault_q <= 2'd3;
                else if (!split_q) rdata_q <= we_q ? '0 : ext;
            end
            if (state == WAIT1 && mem_rsp_valid) begin
                if (mem_rsp_err) fault_q <= 2'd3;
                else             rdata_q <= we_q ? '0 : ext;
            end
            if (accept && !req_we) cnt_loads  <= cnt_loads + CNT_WIDTH'(1);
            if (accept && req_we)  cnt_stores <= cnt_stores + CNT_WIDTH'(1);
            if ((accept && req_fault != 2'd0) || bus_err)
                cnt_faults <= cnt_faults + CNT_WIDTH'(1);
            if (accept && req_fault == 2'd0 && req_split)
                cnt_splits <= cnt_splits + CNT_WIDTH'(1);
        end
    end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit that replaces the single-cycle, mask-only memory stage of the pipelined core. It accepts one load or store at a time from the EX/MEM boundary over a valid/ready handshake and issues byte-lane-correct transactions to the shared memory port. It returns sign/zero-extended load data, or a fault code, to writeback. Misaligned accesses either trap or are split into two bus beats, and the unit keeps its own event counters.

## Interface
- DATA_WIDTH, 64, bus and register width; 32 or 64; NB = DATA_WIDTH/8 byte lanes
- ADDR_WIDTH, 64, address width
- MISALIGN_MODE, 0, 0 = misaligned access faults; 1 = misaligned access is executed, split across two beats when it crosses an NB boundary
- CNT_WIDTH, 32, width of each event counter

Clock and reset:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset

Core-side request:
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, LSB-justified
- req_rd  in  5  destination register

Core-side response:
- rsp_valid  out  1  response present
- rsp_ready  in  1  writeback accepts the response
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
- rsp_rd  out  5  echo of req_rd
- rsp_fault  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 bus error

Memory side:
- mem_req_valid  out  1  beat request
- mem_req_ready  in  1  memory accepts the beat
- mem_we  out  1  write beat
- mem_addr  out  ADDR_WIDTH  NB-aligned beat address
- mem_wdata  out  DATA_WIDTH  lane-positioned write data
- mem_be  out  NB  byte enables
- mem_rsp_valid  in  1  one per accepted beat, in order, including write acks
- mem_rdata  in  DATA_WIDTH  read data
- mem_rsp_err  in  1  bus error for this beat

Counters (free-running, wrap modulo 2^CNT_WIDTH):
- cnt_loads, cnt_stores, cnt_faults, cnt_splits  out  CNT_WIDTH each

## Operation
- Access size: S = 1 << funct3[1:0]. funct3[2] selects unsigned, loads only.
- Legal loads: 000, 001, 010, 100, 101, plus 011 and 110 when DATA_WIDTH = 64.
- Legal stores: 000, 001, 010, plus 011 when DATA_WIDTH = 64.
- Any other funct3 gives fault 2.
- Offset: off = addr mod NB. The access is misaligned when addr mod S != 0.
  - MISALIGN_MODE = 0: misaligned gives fault 1.
  - Illegal funct3 takes priority over misalignment.
- Split: an access splits when MISALIGN_MODE = 1 and off + S > NB.
- Beat 0:
  - mem_addr = addr with the low log2(NB) bits cleared.
  - mem_be = ((1<<S)-1) << off, truncated to NB bits.
  - mem_wdata = wdata << 8*off.
- Beat 1 (split only):
  - mem_addr = beat-0 address + NB.
  - mem_be = (1 << (off+S-NB)) - 1.
  - mem_wdata = wdata >> 8*(NB-off).
- Load assembly:
  - Beat-0 bytes are taken from lanes off..NB-1; beat-1 bytes fill the upper part.
  - The assembled value is extended from bit 8*S-1, with sign per funct3[2]; for S = NB the value passes through unchanged.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - IDLE: req_ready = 1. On handshake, latch the request.
    - If a fault is detected, go to RESP with that fault and issue no memory beat.
    - Otherwise go to ISSUE0.
  - ISSUE0 / ISSUE1: mem_req_valid = 1 with stable fields until mem_req_ready, then go to WAIT0 / WAIT1.
  - WAIT0: on mem_rsp_valid:
    - mem_rsp_err set: go to RESP with fault 3; beat 1 is skipped.
    - Split access: go to ISSUE1.
    - Otherwise: go to RESP.
  - WAIT1: on mem_rsp_valid, go to RESP; fault 3 if mem_rsp_err.
  - RESP: rsp_valid = 1 and all response fields held stable until rsp_ready, then go to IDLE.
- Counters increment on request acceptance:
  - cnt_loads or cnt_stores for every accepted request, faulting or not.
  - cnt_faults when fault 1 or 2 is detected, or on entry to RESP with fault 3.
  - cnt_splits when an access is accepted as a split.
  - Several counters may increment in the same cycle.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored. This covers stale responses after reset.

## Timing
- Reset: state IDLE. req_ready = 1. All other outputs 0: rsp_valid, rsp_rdata, rsp_rd, rsp_fault, mem_*, and all counters.
- Reset mid-transaction aborts immediately. No response is produced.
- Request accepted at edge T:
  - Fault case: rsp_valid is 1 in cycle T+1.
  - Non-fault case: mem_req_valid is 1 in cycle T+1.
- Aligned load with zero-wait memory (mem_req_ready = 1; mem_rsp_valid the cycle after acceptance): rsp_valid in cycle T+3.
- Each additional split beat adds 2 cycles.
- Throughput is at most one access per 4 cycles. There is a single outstanding beat; the unit does no pipelining.
- mem_rdata is sampled only in the cycle mem_rsp_valid = 1.

## Test plan
- DATA_WIDTH=64: LW to 0x1004, mem_rdata = 0x80000000_00000000 -> mem_be = 0xF0, mem_addr = 0x1000, rsp_rdata = 0xFFFFFFFF_80000000 at T+3; LWU to the same address -> 0x00000000_80000000.
- SH of 0xBEEF to 0x2003 with MISALIGN_MODE=0 -> no mem_req_valid, rsp_fault = 1 at T+1, cnt_faults = 1, cnt_stores = 1.
- Same SH with MISALIGN_MODE=1 -> one beat: addr 0x2000, be = 0x18, wdata byte3 = 0xEF, byte4 = 0xBE; cnt_splits stays 0.
- LD from 0x3005 with MISALIGN_MODE=1 -> two beats: (0x3000, be 0xE0), then (0x3008, be 0x1F); rsp_rdata is correctly assembled; cnt_splits = 1; with rsp_ready held low for 3 cycles, rsp_valid stays 1 with fields stable.
- Split store with mem_rsp_err on beat 0 -> no beat 1 is issued, rsp_fault = 3. Also: funct3 = 111, or 011 with DATA_WIDTH = 32 -> rsp_fault = 2.
- Assert rst while in WAIT0, then deliver a late mem_rsp_valid -> unit is in IDLE with all outputs and counters 0, and the late response produces no rsp_valid.
